trigger_unit: RTL and testbench
===============================

Name: trigger_unit

Overview:
Parametrised trigger and capture-sequencing block for the logic analyzer. It combines per-channel trigger conditions and the protocol trigger under a programmable enable mask and an AND/OR mode, and qualifies the combined condition over a programmable number of consecutive cycles. It then counts a programmable number of post-trigger samples and reports capture completion. The capture controller and the sample RAM write logic consume `triggered`, `trig_pulse` and `capture_done`.

Parameters:
NUM_CH, 5, number of channel trigger inputs (>=1)
CNT_W, 16, width of post-trigger sample counter
QUAL_W, 8, width of qualification length field

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
ch_trig  input  NUM_CH  per-channel trigger condition, synchronous to clk
prot_trig  input  1  protocol-decoder trigger condition
ch_en  input  NUM_CH  per-channel enable mask (config)
prot_en  input  1  include prot_trig in the condition (config)
mode  input  1  0 = AND of enabled sources, 1 = OR of enabled sources (config)
qual_len  input  QUAL_W  consecutive true cycles required to fire (config)
post_cnt  input  CNT_W  sample strobes to capture after trigger (config)
arm  input  1  single-cycle arm request
disarm  input  1  single-cycle abort request
smpl_en  input  1  sample strobe from decimator
armed  output  1  waiting for trigger
triggered  output  1  trigger has fired (level)
trig_pulse  output  1  one-cycle pulse in first triggered cycle
capture_done  output  1  post-trigger count complete (level)

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, all outputs 0, counters 0, config shadow registers 0.
- Config shadow: ch_en, prot_en, mode, qual_len and post_cnt are latched on the clock edge on which arm is accepted. Config changes afterwards have no effect until the next arm.
- Combined condition `cond` is combinational from the latched config:
  - Enabled sources = ch_trig & ch_en, plus prot_trig if prot_en.
  - AND mode: all enabled sources are 1.
  - OR mode: any enabled source is 1.
  - No sources enabled: cond = 0 in both modes, so the unit never fires.
- Effective qualification length Q = max(qual_len, 1).
- States:
  - IDLE
  - ARMED
  - POST
  - DONE
- Transitions and per-state behaviour:
  - IDLE: arm -> ARMED; qual counter cleared.
  - ARMED: armed = 1.
    - Qual counter increments each cycle cond = 1 and clears on any cycle cond = 0.
    - If cond is 1 for cycles k..k+Q-1 (k = first ARMED cycle or later), the state is POST from cycle k+Q: triggered = 1 and trig_pulse = 1 for that cycle only. armed drops to 0 in the same cycle.
  - POST: triggered = 1.
    - Down-counter loaded with post_cnt on entry.
    - Counter decrements on each smpl_en that occurs in POST, starting with the entry cycle.
    - When the post_cnt-th strobe is seen, go to DONE and assert capture_done from the next cycle.
    - post_cnt = 0: go to DONE one cycle after entering POST, regardless of smpl_en.
  - DONE: triggered = 1, capture_done = 1, held until arm or disarm.
- Latency: first cycle armed = 1 is the cycle after the arm pulse. cond is evaluated from that cycle on.
- arm in DONE: re-arm. triggered and capture_done clear, new config is latched, state -> ARMED.
- arm in ARMED or POST: ignored.
- disarm in any state: -> IDLE next cycle, all outputs clear. disarm has priority over arm in the same cycle.
- smpl_en outside POST: ignored.
- Counters saturate and never wrap. post_cnt = 2^CNT_W-1 is a valid count.
- cond is level-sensitive: a cond already true when armed qualifies from the first ARMED cycle.

Decomposition:
- Package la_trig_pkg holds:
  - typedef enum trig_state_t {IDLE, ARMED, POST, DONE}
  - constants TRIG_MODE_AND = 1'b0 and TRIG_MODE_OR = 1'b1
- One sub-module, trig_qualifier:
  - Contains the mask/mode combine plus the consecutive-cycle counter.
  - Inputs: the latched config and the trigger inputs.
  - Outputs: a qual_hit strobe.
- The FSM and post-trigger counter stay in trigger_unit.

Test Plan:
- NUM_CH = 5, AND mode, ch_en = 5'b11111, prot_en = 1, Q = 1, post_cnt = 0.
  - Stimulus: arm, then all inputs high 3 cycles later.
  - Required: trig_pulse exactly 1 cycle, triggered on the next edge after cond, capture_done 1 cycle after that.
- OR mode, ch_en = 5'b00100, qual_len = 4.
  - Stimulus: ch_trig[2] high for 3 cycles, low 1, then high 4.
  - Required: no trigger on the first run; trigger in the cycle after the 4th consecutive high cycle.
- ch_en = 0, prot_en = 0, both modes, all inputs high for 100 cycles -> triggered stays 0, armed stays 1.
- post_cnt = 10, smpl_en every 3rd cycle after trigger.
  - Required: capture_done rises the cycle after the 10th strobe counted in POST.
  - Then arm again: triggered and capture_done clear and armed = 1.
- Stimulus: disarm mid-POST, and disarm+arm in the same cycle in ARMED -> IDLE, all outputs 0.
- Stimulus: rst_n asserted mid-POST asynchronously -> all outputs 0 immediately; no trigger after release until arm.

Source files
------------

// File: rtl/trigger_unit_pkg.sv
// Shared types and constants for the logic-analyzer trigger unit.
package la_trig_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } trig_state_t;

  localparam logic TRIG_MODE_AND = 1'b0;
  localparam logic TRIG_MODE_OR  = 1'b1;

endpackage

// File: rtl/trigger_unit_if.sv
// Trigger-unit bus: trigger sources, configuration, control strobes and status.
interface trigger_unit_if #(
  parameter int NUM_CH = 5,
  parameter int CNT_W  = 16,
  parameter int QUAL_W = 8
);
  logic [NUM_CH-1:0] ch_trig;
  logic              prot_trig;
  logic [NUM_CH-1:0] ch_en;
  logic              prot_en;
  logic              mode;
  logic [QUAL_W-1:0] qual_len;
  logic [CNT_W-1:0]  post_cnt;
  logic              arm;
  logic              disarm;
  logic              smpl_en;
  logic              armed;
  logic              triggered;
  logic              trig_pulse;
  logic              capture_done;

  modport master (
    output ch_trig, prot_trig, ch_en, prot_en, mode, qual_len, post_cnt,
    output arm, disarm, smpl_en,
    input  armed, triggered, trig_pulse, capture_done
  );

  modport slave (
    input  ch_trig, prot_trig, ch_en, prot_en, mode, qual_len, post_cnt,
    input  arm, disarm, smpl_en,
    output armed, triggered, trig_pulse, capture_done
  );
endinterface

// File: rtl/trigger_unit_qualifier.sv
// Mask/mode combine of trigger sources plus consecutive-true-cycle qualifier.
// qual_hit is combinational: it is high in the cycle that completes the run.
module trig_qualifier
  import la_trig_pkg::*;
#(
  parameter int NUM_CH = 5,
  parameter int QUAL_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [NUM_CH-1:0] ch_trig,
  input  logic              prot_trig,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              prot_en,
  input  logic              mode,
  input  logic [QUAL_W-1:0] qual_len,
  output logic              qual_hit
);

  logic [NUM_CH:0]   src_en;
  logic [NUM_CH:0]   src_val;
  logic              cond;
  logic [QUAL_W-1:0] q_eff;
  logic [QUAL_W:0]   run_len;
  logic [QUAL_W-1:0] qcnt_q, qcnt_d;

  // Combine enabled sources; with nothing enabled the condition is never true.
  always_comb begin
    src_en  = {prot_en, ch_en};
    src_val = {prot_trig & prot_en, ch_trig & ch_en};
    cond    = 1'b0;
    case (mode)
      TRIG_MODE_AND: cond = (|src_en) & (&(src_val | ~src_en));
      TRIG_MODE_OR:  cond = |src_val;
    endcase
  end

  // Run length including the current cycle vs. effective length max(qual_len,1).
  always_comb begin
    q_eff    = (qual_len == '0) ? QUAL_W'(1) : qual_len;
    run_len  = {1'b0, qcnt_q} + (QUAL_W+1)'(1);
    qual_hit = ~clr & cond & (run_len >= {1'b0, q_eff});
    qcnt_d   = '0;
    if (!clr && cond)
      qcnt_d = (qcnt_q == '1) ? qcnt_q : qcnt_q + QUAL_W'(1);
  end

  // Saturating consecutive-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) qcnt_q <= '0;
    else        qcnt_q <= qcnt_d;
  end

endmodule

// File: rtl/trigger_unit.sv
// Trigger and capture sequencer: arm, qualify, count post-trigger samples, done.
module trigger_unit
  import la_trig_pkg::*;
#(
  parameter int NUM_CH = 5,
  parameter int CNT_W  = 16,
  parameter int QUAL_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  trigger_unit_if.slave bus
);

  // Config shadow, captured when arm is accepted.
  logic [NUM_CH-1:0] cfg_ch_en_q, cfg_ch_en_d;
  logic              cfg_prot_en_q, cfg_prot_en_d;
  logic              cfg_mode_q, cfg_mode_d;
  logic [QUAL_W-1:0] cfg_qual_q, cfg_qual_d;
  logic [CNT_W-1:0]  cfg_post_q, cfg_post_d;

  trig_state_t       state_q, state_d;
  logic [CNT_W-1:0]  pcnt_q, pcnt_d;
  logic              armed_q, armed_d;
  logic              triggered_q, triggered_d;
  logic              trig_pulse_q, trig_pulse_d;
  logic              done_q, done_d;

  logic              arm_ok;
  logic              qual_hit;

  trig_qualifier #(
    .NUM_CH (NUM_CH),
    .QUAL_W (QUAL_W)
  ) u_qual (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (state_q != ARMED),
    .ch_trig   (bus.ch_trig),
    .prot_trig (bus.prot_trig),
    .ch_en     (cfg_ch_en_q),
    .prot_en   (cfg_prot_en_q),
    .mode      (cfg_mode_q),
    .qual_len  (cfg_qual_q),
    .qual_hit  (qual_hit)
  );

  // Arm is only honoured from IDLE or DONE, and never alongside disarm.
  always_comb begin
    arm_ok        = bus.arm & ~bus.disarm & ((state_q == IDLE) | (state_q == DONE));
    cfg_ch_en_d   = arm_ok ? bus.ch_en    : cfg_ch_en_q;
    cfg_prot_en_d = arm_ok ? bus.prot_en  : cfg_prot_en_q;
    cfg_mode_d    = arm_ok ? bus.mode     : cfg_mode_q;
    cfg_qual_d    = arm_ok ? bus.qual_len : cfg_qual_q;
    cfg_post_d    = arm_ok ? bus.post_cnt : cfg_post_q;
  end

  // Config shadow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ch_en_q   <= '0;
      cfg_prot_en_q <= 1'b0;
      cfg_mode_q    <= 1'b0;
      cfg_qual_q    <= '0;
      cfg_post_q    <= '0;
    end else begin
      cfg_ch_en_q   <= cfg_ch_en_d;
      cfg_prot_en_q <= cfg_prot_en_d;
      cfg_mode_q    <= cfg_mode_d;
      cfg_qual_q    <= cfg_qual_d;
      cfg_post_q    <= cfg_post_d;
    end
  end

  // Next state, post-trigger down-counter and registered outputs.
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    case (state_q)
      IDLE:  if (arm_ok) state_d = ARMED;
      ARMED: if (qual_hit) begin
        state_d = POST;
        pcnt_d  = cfg_post_q;
      end
      POST: begin
        if (pcnt_q == '0) begin
          state_d = DONE;
        end else if (bus.smpl_en) begin
          pcnt_d = pcnt_q - CNT_W'(1);
          if (pcnt_q == CNT_W'(1)) state_d = DONE;
        end
      end
      DONE:  if (arm_ok) state_d = ARMED;
    endcase
    if (bus.disarm) begin
      state_d = IDLE;
      pcnt_d  = '0;
    end
    armed_d      = (state_d == ARMED);
    triggered_d  = (state_d == POST) | (state_d == DONE);
    trig_pulse_d = (state_q == ARMED) & (state_d == POST);
    done_d       = (state_d == DONE);
  end

  // FSM state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pcnt_q       <= '0;
      armed_q      <= 1'b0;
      triggered_q  <= 1'b0;
      trig_pulse_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pcnt_q       <= pcnt_d;
      armed_q      <= armed_d;
      triggered_q  <= triggered_d;
      trig_pulse_q <= trig_pulse_d;
      done_q       <= done_d;
    end
  end

  assign bus.armed        = armed_q;
  assign bus.triggered    = triggered_q;
  assign bus.trig_pulse   = trig_pulse_q;
  assign bus.capture_done = done_q;

endmodule

// File: tb/tb_trigger_unit.sv
// Directed bench for trigger_unit. Expected status {armed,triggered,pulse,done}
// is queued with each driven step and checked after the following clock edge.
module tb_trigger_unit;
  localparam int NUM_CH = 5;
  localparam int CNT_W  = 16;
  localparam int QUAL_W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  logic [3:0] exp_q[$];
  string      tag_q[$];

  trigger_unit_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .QUAL_W(QUAL_W)) bus ();

  trigger_unit #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .QUAL_W(QUAL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic pop_chk();
    logic [3:0] e, o;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = {bus.armed, bus.triggered, bus.trig_pulse, bus.capture_done};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: got atpd=%b want atpd=%b", t, o, e);
    end
  endtask

  // Check now, without a clock edge.
  task automatic now(input logic [3:0] e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
    pop_chk();
  endtask

  // Clock one cycle with the currently driven inputs, then check.
  task automatic cyc(input logic [3:0] e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
    pop_chk();
  endtask

  task automatic cfg(input logic [NUM_CH-1:0] ce, input logic pe, input logic md,
                     input logic [QUAL_W-1:0] ql, input logic [CNT_W-1:0] pc);
    bus.ch_en    = ce;
    bus.prot_en  = pe;
    bus.mode     = md;
    bus.qual_len = ql;
    bus.post_cnt = pc;
  endtask

  initial begin
    int cnt;
    rst_n         = 1'b0;
    bus.ch_trig   = '0;
    bus.prot_trig = 1'b0;
    bus.arm       = 1'b0;
    bus.disarm    = 1'b0;
    bus.smpl_en   = 1'b0;
    cfg('0, 1'b0, 1'b0, '0, '0);
    #1;
    now(4'b0000, "reset");
    cyc(4'b0000, "reset_clk");
    rst_n = 1'b1;

    // 1: AND mode, all sources, Q=1, post_cnt=0; config changed after arm.
    cfg(5'b11111, 1'b1, 1'b0, 8'd1, 16'd0);
    bus.arm = 1'b1;
    cyc(4'b1000, "t1_arm");
    bus.arm = 1'b0;
    cfg('0, 1'b0, 1'b1, 8'd9, 16'd5);
    cyc(4'b1000, "t1_wait1");
    cyc(4'b1000, "t1_wait2");
    bus.ch_trig = 5'b11111; bus.prot_trig = 1'b1;
    cyc(4'b0110, "t1_fire");
    cyc(4'b0101, "t1_done");
    bus.ch_trig = '0; bus.prot_trig = 1'b0;
    cyc(4'b0101, "t1_hold");

    // 2: re-arm from DONE, OR mode, ch2 only, Q=4; prot_trig high but masked.
    cfg(5'b00100, 1'b0, 1'b1, 8'd4, 16'd0);
    bus.prot_trig = 1'b1;
    bus.arm = 1'b1;
    cyc(4'b1000, "t2_rearm");
    bus.arm = 1'b0;
    bus.ch_trig = 5'b00100;
    for (int i = 0; i < 3; i++) cyc(4'b1000, $sformatf("t2_run3_%0d", i));
    bus.ch_trig = '0;
    cyc(4'b1000, "t2_gap");
    bus.ch_trig = 5'b00100;
    for (int i = 0; i < 3; i++) cyc(4'b1000, $sformatf("t2_run4_%0d", i));
    cyc(4'b0110, "t2_fire");
    bus.ch_trig = '0; bus.prot_trig = 1'b0;
    cyc(4'b0101, "t2_done");

    // 3: no sources enabled never fires, in both modes.
    for (int m = 0; m < 2; m++) begin
      bus.disarm = 1'b1;
      cyc(4'b0000, $sformatf("t3_disarm_m%0d", m));
      bus.disarm = 1'b0;
      cfg('0, 1'b0, m[0], 8'd1, 16'd0);
      bus.arm = 1'b1;
      cyc(4'b1000, $sformatf("t3_arm_m%0d", m));
      bus.arm = 1'b0;
      bus.ch_trig = '1; bus.prot_trig = 1'b1;
      for (int i = 0; i < 100; i++) cyc(4'b1000, $sformatf("t3_m%0d_c%0d", m, i));
      bus.ch_trig = '0; bus.prot_trig = 1'b0;
    end
    bus.disarm = 1'b1;
    cyc(4'b0000, "t3_end");
    bus.disarm = 1'b0;

    // 4: post_cnt=10, strobe every 3rd POST cycle; strobes outside POST ignored.
    cfg(5'b00001, 1'b0, 1'b1, 8'd0, 16'd10);
    bus.smpl_en = 1'b1;
    bus.arm = 1'b1;
    cyc(4'b1000, "t4_arm");
    bus.arm = 1'b0;
    bus.ch_trig = 5'b00001;
    cyc(4'b0110, "t4_fire");
    bus.ch_trig = '0;
    cnt = 0;
    for (int i = 0; i < 40 && cnt < 10; i++) begin
      bus.smpl_en = (i % 3 == 2);
      if (bus.smpl_en) cnt++;
      cyc((cnt >= 10) ? 4'b0101 : 4'b0100, $sformatf("t4_post_%0d", i));
    end
    bus.smpl_en = 1'b0;
    cyc(4'b0101, "t4_hold");
    bus.arm = 1'b1;
    cyc(4'b1000, "t4_rearm");
    bus.arm = 1'b0;

    // 5: arm ignored in POST, disarm mid-POST, disarm+arm together in ARMED.
    bus.ch_trig = 5'b00001;
    cyc(4'b0110, "t5_fire");
    bus.ch_trig = '0;
    bus.arm = 1'b1;
    cyc(4'b0100, "t5_arm_in_post");
    bus.arm = 1'b0;
    bus.disarm = 1'b1;
    cyc(4'b0000, "t5_disarm_post");
    bus.disarm = 1'b0;
    bus.ch_trig = 5'b00001;
    cyc(4'b0000, "t5_idle_no_fire");
    bus.ch_trig = '0;
    bus.arm = 1'b1;
    cyc(4'b1000, "t5_arm");
    bus.disarm = 1'b1;
    cyc(4'b0000, "t5_disarm_and_arm");
    bus.arm = 1'b0; bus.disarm = 1'b0;
    bus.ch_trig = 5'b00001;
    cyc(4'b0000, "t5_idle1");
    cyc(4'b0000, "t5_idle2");
    bus.ch_trig = '0;

    // 6: asynchronous reset in POST clears immediately; nothing until next arm.
    bus.arm = 1'b1;
    cyc(4'b1000, "t6_arm");
    bus.arm = 1'b0;
    bus.ch_trig = 5'b00001;
    cyc(4'b0110, "t6_fire");
    cyc(4'b0100, "t6_post");
    #2 rst_n = 1'b0;
    #1;
    now(4'b0000, "t6_async_rst");
    cyc(4'b0000, "t6_rst_held");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(4'b0000, $sformatf("t6_after_rst_%0d", i));
    bus.arm = 1'b1;
    cyc(4'b1000, "t6_rearm");
    bus.arm = 1'b0;
    cyc(4'b0110, "t6_fire2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
